// File: rtl/xmit_frame_gen.sv
// Burst frame traffic generator: programmed count/length/gap/priority/pattern, with hold and abort.
// Latency: start -> first beat 1 cycle; hold gates valids in the same cycle and freezes all counters.
module xmit_frame_gen #(
    parameter int          DATA_W   = 8,
    parameter int          LEN_W    = 16,
    parameter int          CNT_W    = 8,
    parameter logic [7:0]  CTRL_TAG = 8'h0F,
    parameter int          CTRL_W   = 24
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic [CNT_W-1:0]  cfg_num,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_gap,
    input  logic [1:0]        cfg_prio,
    input  logic              cfg_pat,
    output logic [DATA_W-1:0] f_data_out,
    output logic              f_data_valid,
    output logic [CTRL_W-1:0] f_ctrl_out,
    output logic              f_frame_valid,
    output logic              f_hi_priority,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int HW = DATA_W / 2;

    typedef enum logic [2:0] {S_IDLE, S_FRAME, S_GAP, S_EMPTY, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   num_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   gap_q;
    logic [1:0]         prio_q;
    logic               pat_q;
    logic [CNT_W-1:0]   frame_idx;
    logic [LEN_W-1:0]   beat;
    logic [CNT_W-1:0]   gap_cnt;
    logic               first;

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state     <= S_IDLE;
            num_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            prio_q    <= '0;
            pat_q     <= 1'b0;
            frame_idx <= '0;
            beat      <= '0;
            gap_cnt   <= '0;
            first     <= 1'b0;
            frame_cnt <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            first <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_q     <= cfg_num;
                        len_q     <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                        gap_q     <= cfg_gap;
                        prio_q    <= cfg_prio;
                        pat_q     <= cfg_pat;
                        frame_idx <= '0;
                        beat      <= '0;
                        first     <= 1'b1;
                        frame_cnt <= '0;
                        // An empty burst still spends one busy cycle before reporting done.
                        state     <= (cfg_num == '0) ? S_EMPTY : S_FRAME;
                    end
                end
                S_FRAME: begin
                    if (!hold) begin
                        first <= 1'b0;
                        if (beat == len_q - LEN_W'(1)) begin
                            beat <= '0;
                            if (frame_cnt != {CNT_W{1'b1}})
                                frame_cnt <= frame_cnt + CNT_W'(1);
                            if (frame_idx == num_q - CNT_W'(1)) begin
                                state <= S_DONE;
                            end else begin
                                frame_idx <= frame_idx + CNT_W'(1);
                                first     <= 1'b1;
                                if (gap_q == '0) begin
                                    state <= S_FRAME;
                                end else begin
                                    gap_cnt <= gap_q - CNT_W'(1);
                                    state   <= S_GAP;
                                end
                            end
                        end else begin
                            beat <= beat + LEN_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (!hold) begin
                        if (gap_cnt == '0)
                            state <= S_FRAME;
                        else
                            gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end
                S_EMPTY: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic in_frame;
    assign in_frame = (state == S_FRAME);

    // Beat contents are held across hold cycles; only the valids are withdrawn.
    assign f_data_valid  = in_frame & ~hold;
    assign f_frame_valid = f_data_valid & first;
    assign f_ctrl_out    = f_frame_valid ? CTRL_W'({CTRL_TAG, len_q}) : '0;
    assign f_data_out    = !in_frame ? '0 :
                           pat_q     ? {DATA_W{1'b1}} :
                                       {HW'(frame_idx), HW'(beat)};
    assign f_hi_priority = in_frame & ((prio_q == 2'b01) | ((prio_q == 2'b10) & ~frame_idx[0]));
    assign busy          = in_frame | (state == S_GAP) | (state == S_EMPTY);
    assign done          = (state == S_DONE);
endmodule
